// File: rtl/alu_mc_unit_if.sv
// rtl/alu_mc_unit_if.sv - operation/result handshake bundle for the multi-cycle execute unit
interface alu_mc_unit_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALUOP_WIDTH = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ALUOP_WIDTH-1:0] alu_op;
  logic [6:0]             op;
  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic [DATA_WIDTH-1:0]  src_a;
  logic [DATA_WIDTH-1:0]  src_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  result;
  logic                   zero;
  logic                   illegal;
  logic                   busy;

  modport master (
    output in_valid, alu_op, op, funct3, funct7, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, op, funct3, funct7, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal, busy
  );
endinterface

// File: rtl/alu_mc_unit.sv
// rtl/alu_mc_unit.sv - multi-cycle execute unit: decode, single-cycle ALU, iterative shifts, shift-add MUL
module alu_mc_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALUOP_WIDTH = 3,
  parameter int EN_MUL      = 1
) (
  input logic         clk,
  input logic         rst_n,
  alu_mc_unit_if.slave bus
);
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_MUL   = 2'b10;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  localparam logic [SHW:0] CNT_ONE    = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0] MUL_CYCLES = (SHW+1)'(DATA_WIDTH);

  logic [1:0]            state;
  logic [SHW:0]          cnt;
  logic [3:0]            kind;
  logic [DATA_WIDTH-1:0] work_a;
  logic [DATA_WIDTH-1:0] work_b;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic                  illegal_q;
  logic                  out_valid_q;

  logic [3:0]            dec_op;
  logic                  dec_illegal;
  logic [DATA_WIDTH-1:0] single_res;
  logic [DATA_WIDTH-1:0] sh_next;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [SHW-1:0]        shamt;
  logic                  is_shift;
  logic                  accept;

  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    if (bus.alu_op == '0) begin
      if (bus.op == 7'b0110011 && bus.funct7 == 7'b0000001) begin
        if (bus.funct3 == 3'b000 && EN_MUL != 0) dec_op = OP_MUL;
        else                                    dec_illegal = 1'b1;
      end else begin
        case (bus.funct3)
          3'b000:  dec_op = (bus.op[5] && bus.funct7[5]) ? OP_SUB : OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = bus.funct7[5] ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
    end else if (bus.alu_op == ALUOP_WIDTH'(3)) begin
      dec_op = OP_SUB;
    end else if (bus.alu_op == ALUOP_WIDTH'(5)) begin
      dec_op = OP_PASSB;
    end
  end

  // Shift ops only complete here when shamt is zero, so they simply pass src_a.
  always_comb begin
    single_res = '0;
    case (dec_op)
      OP_ADD:   single_res = bus.src_a + bus.src_b;
      OP_SUB:   single_res = bus.src_a - bus.src_b;
      OP_SLT:   single_res[0] = $signed(bus.src_a) < $signed(bus.src_b);
      OP_SLTU:  single_res[0] = bus.src_a < bus.src_b;
      OP_XOR:   single_res = bus.src_a ^ bus.src_b;
      OP_OR:    single_res = bus.src_a | bus.src_b;
      OP_AND:   single_res = bus.src_a & bus.src_b;
      OP_PASSB: single_res = bus.src_b;
      OP_SLL, OP_SRL, OP_SRA: single_res = bus.src_a;
      default:  single_res = '0;
    endcase
    if (dec_illegal) single_res = '0;
  end

  always_comb begin
    case (kind)
      OP_SLL:  sh_next = {work_a[DATA_WIDTH-2:0], 1'b0};
      OP_SRA:  sh_next = {work_a[DATA_WIDTH-1], work_a[DATA_WIDTH-1:1]};
      default: sh_next = {1'b0, work_a[DATA_WIDTH-1:1]};
    endcase
  end

  assign acc_next = acc + (work_b[0] ? work_a : '0);
  assign shamt    = bus.src_b[SHW-1:0];
  assign is_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);
  assign accept   = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      kind        <= OP_ADD;
      work_a      <= '0;
      work_b      <= '0;
      acc         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // A same-cycle single-cycle accept below overrides this clear.
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift && shamt != '0) begin
              state  <= ST_SHIFT;
              work_a <= bus.src_a;
              cnt    <= {1'b0, shamt};
              kind   <= dec_op;
            end else if (dec_op == OP_MUL) begin
              state  <= ST_MUL;
              work_a <= bus.src_a;
              work_b <= bus.src_b;
              acc    <= '0;
              cnt    <= MUL_CYCLES;
            end else begin
              result_q    <= single_res;
              zero_q      <= (single_res == '0);
              illegal_q   <= dec_illegal;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          work_a <= sh_next;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            result_q    <= sh_next;
            zero_q      <= (sh_next == '0);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          work_a <= work_a << 1;
          work_b <= work_b >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            result_q    <= acc_next;
            zero_q      <= (acc_next == '0);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc_unit.sv
// tb/tb_alu_mc_unit.sv - directed-vector bench for alu_mc_unit with EN_MUL=1 and EN_MUL=0 builds
module tb_alu_mc_unit;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int miscompares = 0;

  alu_mc_unit_if #(.DATA_WIDTH(32), .ALUOP_WIDTH(3)) bus ();
  alu_mc_unit_if #(.DATA_WIDTH(32), .ALUOP_WIDTH(3)) bus0 ();

  alu_mc_unit #(.DATA_WIDTH(32), .ALUOP_WIDTH(3), .EN_MUL(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  alu_mc_unit #(.DATA_WIDTH(32), .ALUOP_WIDTH(3), .EN_MUL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] aop, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    bus.alu_op   = aop;
    bus.op       = o;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
  endtask

  // Issues one op and waits for out_valid; lat is cycles after the accept cycle.
  task automatic run_op(input logic [2:0] aop, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    drive(aop, o, f3, f7, a, b);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!bus.out_valid && lat < 64) begin
      if (bus.busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h want 0", bus.result); end
    vectors++; if ({bus.zero, bus.illegal, bus.busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {bus.zero, bus.illegal, bus.busy}); end
  endtask

  task automatic test_single_cycle();
    int lat, bc;
    run_op(3'b000, OP_R, 3'b000, 7'h00, 32'h7FFFFFFF, 32'h1, lat, bc);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL add_latency: got %0d want 1", lat); end
    vectors++; if ({bus.result, bus.zero} !== {32'h80000000, 1'b0}) begin miscompares++; $display("FAIL add_ovf: got %h/%b want 80000000/0", bus.result, bus.zero); end
    run_op(3'b011, OP_R, 3'b000, 7'h00, 32'h5, 32'h5, lat, bc);
    vectors++; if ({bus.result, bus.zero} !== {32'h0, 1'b1}) begin miscompares++; $display("FAIL sub_beq: got %h/%b want 0/1", bus.result, bus.zero); end
    run_op(3'b000, OP_R, 3'b010, 7'h00, 32'hFFFFFFFF, 32'h1, lat, bc);
    vectors++; if (bus.result !== 32'h1) begin miscompares++; $display("FAIL slt: got %h want 1", bus.result); end
    run_op(3'b000, OP_R, 3'b011, 7'h00, 32'hFFFFFFFF, 32'h1, lat, bc);
    vectors++; if ({bus.result, bus.zero} !== {32'h0, 1'b1}) begin miscompares++; $display("FAIL sltu: got %h/%b want 0/1", bus.result, bus.zero); end
    run_op(3'b000, OP_R, 3'b000, 7'h20, 32'd10, 32'd3, lat, bc);
    vectors++; if (bus.result !== 32'd7) begin miscompares++; $display("FAIL r_sub: got %h want 7", bus.result); end
    run_op(3'b000, OP_I, 3'b000, 7'h20, 32'd10, 32'd3, lat, bc);
    vectors++; if (bus.result !== 32'd13) begin miscompares++; $display("FAIL addi_f7: got %h want d", bus.result); end
    run_op(3'b000, OP_R, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, lat, bc);
    vectors++; if (bus.result !== 32'h0FF00FF0) begin miscompares++; $display("FAIL xor: got %h want 0ff00ff0", bus.result); end
    run_op(3'b000, OP_R, 3'b110, 7'h00, 32'hF0F0F0F0, 32'h0000FF00, lat, bc);
    vectors++; if (bus.result !== 32'hF0F0FFF0) begin miscompares++; $display("FAIL or: got %h want f0f0fff0", bus.result); end
    run_op(3'b000, OP_R, 3'b111, 7'h00, 32'hF0F0F0F0, 32'h0000FF00, lat, bc);
    vectors++; if (bus.result !== 32'h0000F000) begin miscompares++; $display("FAIL and: got %h want 0000f000", bus.result); end
    run_op(3'b101, OP_R, 3'b111, 7'h00, 32'h12345678, 32'hABCDE000, lat, bc);
    vectors++; if (bus.result !== 32'hABCDE000) begin miscompares++; $display("FAIL lui: got %h want abcde000", bus.result); end
    run_op(3'b000, OP_R, 3'b001, 7'h00, 32'hDEADBEEF, 32'h20, lat, bc);
    vectors++; if ({lat, bus.result} !== {32'd1, 32'hDEADBEEF}) begin miscompares++; $display("FAIL sll_shamt0: got lat %0d %h want 1 deadbeef", lat, bus.result); end
    step();
  endtask

  task automatic test_shift();
    int lat, bc;
    drive(3'b000, OP_R, 3'b101, 7'h20, 32'h80000000, 32'd4);
    step();
    bus.in_valid = 1'b0;
    vectors++; if ({bus.busy, bus.in_ready} !== 2'b10) begin miscompares++; $display("FAIL shift_busy_ready: got %b want 10", {bus.busy, bus.in_ready}); end
    step();
    step();
    step();
    step();
    vectors++; if ({bus.out_valid, bus.busy, bus.result} !== {2'b10, 32'hF8000000}) begin miscompares++; $display("FAIL sra_t5: got %b%b %h want 10 f8000000", bus.out_valid, bus.busy, bus.result); end
    step();
    run_op(3'b000, OP_R, 3'b101, 7'h20, 32'h80000000, 32'd4, lat, bc);
    vectors++; if ({lat, bc} !== {32'd5, 32'd4}) begin miscompares++; $display("FAIL sra_timing: got lat %0d busy %0d want 5 4", lat, bc); end
    run_op(3'b000, OP_R, 3'b101, 7'h00, 32'h80000000, 32'd31, lat, bc);
    vectors++; if ({lat, bus.result} !== {32'd32, 32'h1}) begin miscompares++; $display("FAIL srl31: got lat %0d %h want 32 1", lat, bus.result); end
    run_op(3'b000, OP_I, 3'b001, 7'h00, 32'h1, 32'd3, lat, bc);
    vectors++; if ({lat, bus.result} !== {32'd4, 32'h8}) begin miscompares++; $display("FAIL sll3: got lat %0d %h want 4 8", lat, bus.result); end
    step();
  endtask

  task automatic test_mul();
    int lat, bc;
    run_op(3'b000, OP_R, 3'b000, 7'h01, 32'h10000, 32'h10000, lat, bc);
    vectors++; if ({lat, bus.result, bus.zero} !== {32'd33, 32'h0, 1'b1}) begin miscompares++; $display("FAIL mul_wrap: got lat %0d %h/%b want 33 0/1", lat, bus.result, bus.zero); end
    run_op(3'b000, OP_R, 3'b000, 7'h01, 32'h3, 32'hFFFFFFFF, lat, bc);
    vectors++; if ({lat, bc, bus.result} !== {32'd33, 32'd32, 32'hFFFFFFFD}) begin miscompares++; $display("FAIL mul_neg: got lat %0d busy %0d %h want 33 32 fffffffd", lat, bc, bus.result); end
    run_op(3'b000, OP_R, 3'b000, 7'h01, 32'd7, 32'd6, lat, bc);
    vectors++; if (bus.result !== 32'd42) begin miscompares++; $display("FAIL mul_small: got %h want 2a", bus.result); end
    run_op(3'b000, OP_R, 3'b001, 7'h01, 32'h3, 32'h5, lat, bc);
    vectors++; if ({lat, bus.illegal, bus.zero, bus.result} !== {32'd1, 2'b11, 32'h0}) begin miscompares++; $display("FAIL mulh_illegal: got lat %0d %b%b %h want 1 11 0", lat, bus.illegal, bus.zero, bus.result); end
    step();
  endtask

  task automatic test_no_mul();
    bus0.alu_op   = 3'b000;
    bus0.op       = OP_R;
    bus0.funct3   = 3'b000;
    bus0.funct7   = 7'h01;
    bus0.src_a    = 32'h3;
    bus0.src_b    = 32'hFFFFFFFF;
    bus0.in_valid = 1'b1;
    step();
    bus0.in_valid = 1'b0;
    vectors++; if ({bus0.out_valid, bus0.illegal, bus0.zero, bus0.busy, bus0.result} !== {4'b1110, 32'h0}) begin miscompares++; $display("FAIL nomul_illegal: got %b%b%b%b %h want 1110 0", bus0.out_valid, bus0.illegal, bus0.zero, bus0.busy, bus0.result); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, OP_R, 3'b000, 7'h00, 32'h100 * (i + 1), 32'(i));
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d: got %b want 1", i, bus.in_ready); end
      step();
      exp = 32'h100 * (i + 1) + 32'(i);
      vectors++; if ({bus.out_valid, bus.result} !== {1'b1, exp}) begin miscompares++; $display("FAIL b2b_result%0d: got %b %h want 1 %h", i, bus.out_valid, bus.result, exp); end
    end
    bus.in_valid = 1'b0;
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    int lat, bc;
    bus.out_ready = 1'b0;
    run_op(3'b000, OP_R, 3'b000, 7'h00, 32'd2, 32'd3, lat, bc);
    drive(3'b000, OP_R, 3'b000, 7'h00, 32'd10, 32'd20);
    for (int i = 0; i < 3; i++) begin
      vectors++; if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b10, 32'd5}) begin miscompares++; $display("FAIL stall%0d: got %b%b %h want 10 5", i, bus.out_valid, bus.in_ready, bus.result); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    vectors++; if ({bus.out_valid, bus.result} !== {1'b1, 32'd30}) begin miscompares++; $display("FAIL stall_next: got %b %h want 1 1e", bus.out_valid, bus.result); end
    step();
  endtask

  task automatic test_reset_mid_mul();
    int lat, bc;
    drive(3'b000, OP_R, 3'b000, 7'h01, 32'd3, 32'd5);
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mul_busy_c10: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({bus.out_valid, bus.busy, bus.zero, bus.illegal, bus.result} !== {4'b0000, 32'h0}) begin miscompares++; $display("FAIL mid_reset: got %b%b%b%b %h want 0000 0", bus.out_valid, bus.busy, bus.zero, bus.illegal, bus.result); end
    step();
    rst_n = 1'b1;
    step();
    run_op(3'b000, OP_R, 3'b000, 7'h00, 32'd6, 32'd7, lat, bc);
    vectors++; if ({lat, bus.result} !== {32'd1, 32'd13}) begin miscompares++; $display("FAIL post_reset_add: got lat %0d %h want 1 d", lat, bus.result); end
    step();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_op    = '0;
    bus.op        = '0;
    bus.funct3    = '0;
    bus.funct7    = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0;
    bus0.alu_op   = '0;
    bus0.op       = '0;
    bus0.funct3   = '0;
    bus0.funct7   = '0;
    bus0.src_a    = '0;
    bus0.src_b    = '0;
    bus0.out_ready = 1'b1;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_single_cycle();
    test_shift();
    test_mul();
    test_no_mul();
    test_back_to_back();
    test_stall();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
